// File: rtl/rgb_tmds_encoder.sv
// DVI 1.0 TMDS encoder: RGB888 plus HS/VS/DE become three 10-bit TMDS words.
// Each channel has two pipeline stages: the q_m transition-minimising stage, then the DC-balancing stage.

module tmds_channel (
    input  logic       pixel_clk,
    input  logic       rst_n,
    input  logic [7:0] i_data,
    input  logic       i_c0,
    input  logic       i_c1,
    input  logic       i_de,
    output logic [9:0] o_tmds
);

    logic [3:0]        w_n1;
    logic              w_xnor;
    logic [8:0]        w_qm;

    logic [8:0]        r_qm;
    logic              r_de;
    logic              r_c0;
    logic              r_c1;

    logic [3:0]        w_n1q;
    logic signed [4:0] w_diff;      // n1q - n0q, always even, -8..+8
    logic signed [4:0] w_qm8_x2;
    logic signed [4:0] w_nqm8_x2;
    logic signed [4:0] w_cnt_next;
    logic [9:0]        w_word;

    logic signed [4:0] r_cnt;
    logic [9:0]        r_word;

    // Stage 1: choose XOR or XNOR chaining so the word has fewer transitions.
    always_comb begin
        w_n1   = 4'($countones(i_data));
        w_xnor = (w_n1 > 4'd4) || ((w_n1 == 4'd4) && !i_data[0]);
        w_qm    = '0;
        w_qm[0] = i_data[0];
        for (int i = 1; i < 8; i++) begin
            w_qm[i] = w_xnor ? ~(w_qm[i-1] ^ i_data[i]) : (w_qm[i-1] ^ i_data[i]);
        end
        w_qm[8] = ~w_xnor;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_qm <= '0;
            r_de <= 1'b0;
            r_c0 <= 1'b0;
            r_c1 <= 1'b0;
        end else begin
            r_qm <= w_qm;
            r_de <= i_de;
            r_c0 <= i_c0;
            r_c1 <= i_c1;
        end
    end

    // Stage 2: invert or pass q_m[7:0] to steer the running disparity back toward zero.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_word     = '0;
        w_cnt_next = r_cnt;
        w_n1q      = 4'($countones(r_qm[7:0]));
        w_diff     = 5'({w_n1q, 1'b0}) - 5'sd8;
        w_qm8_x2   = {3'b000, r_qm[8], 1'b0};
        w_nqm8_x2  = {3'b000, ~r_qm[8], 1'b0};
        if (!r_de) begin
            case ({r_c1, r_c0})
                2'b00:   w_word = 10'b1101010100;
                2'b01:   w_word = 10'b0010101011;
                2'b10:   w_word = 10'b0101010100;
                default: w_word = 10'b1010101011;
            endcase
            w_cnt_next = '0;
        end else if ((r_cnt == 5'sd0) || (w_diff == 5'sd0)) begin
            w_word     = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
            w_cnt_next = r_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
        end else if (r_cnt[4] == w_diff[4]) begin
            // Both non-zero with the same sign: the word would grow the imbalance.
            w_word     = {1'b1, r_qm[8], ~r_qm[7:0]};
            w_cnt_next = r_cnt + w_qm8_x2 - w_diff;
        end else begin
            w_word     = {1'b0, r_qm[8], r_qm[7:0]};
            w_cnt_next = r_cnt + w_diff - w_nqm8_x2;
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_word <= w_word;
        end
    end

    assign o_tmds = r_word;

endmodule

module rgb_tmds_encoder #(
    parameter bit INVERT_SYNC = 1'b0
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic        video_hs,
    input  logic        video_vs,
    input  logic        video_de,
    input  logic [23:0] video_rgb,
    output logic [9:0]  tmds_ch0,
    output logic [9:0]  tmds_ch1,
    output logic [9:0]  tmds_ch2
);

    logic w_hs;
    logic w_vs;

    assign w_hs = video_hs ^ INVERT_SYNC;
    assign w_vs = video_vs ^ INVERT_SYNC;

    tmds_channel u_ch0 (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .i_data    (video_rgb[7:0]),
        .i_c0      (w_hs),
        .i_c1      (w_vs),
        .i_de      (video_de),
        .o_tmds    (tmds_ch0)
    );

    tmds_channel u_ch1 (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .i_data    (video_rgb[15:8]),
        .i_c0      (1'b0),
        .i_c1      (1'b0),
        .i_de      (video_de),
        .o_tmds    (tmds_ch1)
    );

    tmds_channel u_ch2 (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .i_data    (video_rgb[23:16]),
        .i_c0      (1'b0),
        .i_c1      (1'b0),
        .i_de      (video_de),
        .o_tmds    (tmds_ch2)
    );

endmodule

// File: tb/tb_rgb_tmds_encoder.sv
// Directed bench for rgb_tmds_encoder: reset, control words, DC balance, de gaps, sync inversion,
// then a short blanked pixel stream compared word-for-word against a behavioural encoder.

module tb_rgb_tmds_encoder;

    localparam logic [9:0] CTL00 = 10'b1101010100;
    localparam logic [9:0] CTL01 = 10'b0010101011;
    localparam logic [9:0] CTL10 = 10'b0101010100;
    localparam logic [9:0] CTL11 = 10'b1010101011;

    logic        pixel_clk = 1'b0;
    logic        rst_n     = 1'b0;
    logic        video_hs  = 1'b1;
    logic        video_vs  = 1'b1;
    logic        video_de  = 1'b0;
    logic [23:0] video_rgb = '0;
    logic [9:0]  ch0, ch1, ch2;
    logic [9:0]  inv_ch0, inv_ch1, inv_ch2;

    int n_assert = 0;
    int n_fail   = 0;

    int         m_cnt [4];
    logic [9:0] exp_prev [4];
    bit         prev_valid = 1'b0;

    always #5 pixel_clk = ~pixel_clk;

    rgb_tmds_encoder #(.INVERT_SYNC(1'b0)) dut (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .video_hs  (video_hs),
        .video_vs  (video_vs),
        .video_de  (video_de),
        .video_rgb (video_rgb),
        .tmds_ch0  (ch0),
        .tmds_ch1  (ch1),
        .tmds_ch2  (ch2)
    );

    rgb_tmds_encoder #(.INVERT_SYNC(1'b1)) dut_inv (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .video_hs  (video_hs),
        .video_vs  (video_vs),
        .video_de  (video_de),
        .video_rgb (video_rgb),
        .tmds_ch0  (inv_ch0),
        .tmds_ch1  (inv_ch1),
        .tmds_ch2  (inv_ch2)
    );

    task automatic check(input string tag, input logic [9:0] observed, input logic [9:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge pixel_clk);
        #1;
    endtask

    // Output after each drive reflects the vector applied by the previous drive.
    task automatic drive(input logic de, input logic hs, input logic vs, input logic [23:0] rgb);
        video_de  = de;
        video_hs  = hs;
        video_vs  = vs;
        video_rgb = rgb;
        step();
    endtask

    // Behavioural DVI 1.0 encoder, integer arithmetic, one disparity counter per stream.
    function automatic logic [9:0] model_enc(input int ch, input logic [7:0] d,
                                             input logic c0, input logic c1, input logic de);
        int         n1, n1q, n0q;
        bit         use_xnor;
        logic [8:0] qm;
        logic [9:0] w;
        if (!de) begin
            m_cnt[ch] = 0;
            case ({c1, c0})
                2'b00:   w = CTL00;
                2'b01:   w = CTL01;
                2'b10:   w = CTL10;
                default: w = CTL11;
            endcase
        end else begin
            n1       = $countones(d);
            use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
            qm[0]    = d[0];
            for (int i = 1; i < 8; i++)
                qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
            qm[8] = !use_xnor;
            n1q   = $countones(qm[7:0]);
            n0q   = 8 - n1q;
            if (m_cnt[ch] == 0 || n1q == n0q) begin
                w = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                m_cnt[ch] += qm[8] ? (n1q - n0q) : (n0q - n1q);
            end else if ((m_cnt[ch] > 0 && n1q > n0q) || (m_cnt[ch] < 0 && n0q > n1q)) begin
                w = {1'b1, qm[8], ~qm[7:0]};
                m_cnt[ch] += 2 * int'(qm[8]) + (n0q - n1q);
            end else begin
                w = {1'b0, qm[8], qm[7:0]};
                m_cnt[ch] += (n1q - n0q) - 2 * int'(!qm[8]);
            end
        end
        return w;
    endfunction

    task automatic drive_model(input logic de, input logic hs, input logic vs, input logic [23:0] rgb);
        logic [9:0] e [4];
        e[0] = model_enc(0, rgb[7:0],   hs,  vs,  de);
        e[1] = model_enc(1, rgb[15:8],  1'b0, 1'b0, de);
        e[2] = model_enc(2, rgb[23:16], 1'b0, 1'b0, de);
        e[3] = model_enc(3, rgb[7:0],   ~hs, ~vs, de);
        drive(de, hs, vs, rgb);
        if (prev_valid) begin
            check("stream_ch0", ch0, exp_prev[0]);
            check("stream_ch1", ch1, exp_prev[1]);
            check("stream_ch2", ch2, exp_prev[2]);
            check("stream_inv_ch0", inv_ch0, exp_prev[3]);
        end
        exp_prev   = e;
        prev_valid = 1'b1;
    endtask

    initial begin
        logic [9:0] exp_word;
        bit         de_s;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;

        // Reset holds every output at zero.
        step();
        step();
        check("reset_ch0", ch0, 10'd0);
        check("reset_ch1", ch1, 10'd0);
        check("reset_ch2", ch2, 10'd0);
        check("reset_inv_ch0", inv_ch0, 10'd0);

        // Release with de=0, hs=vs=1: valid control words after two edges.
        rst_n = 1'b1;
        step();
        step();
        check("rel_ch0", ch0, CTL11);
        check("rel_ch1", ch1, CTL00);
        check("rel_ch2", ch2, CTL00);
        check("rel_inv_ch0", inv_ch0, CTL00);

        // Remaining sync combinations on both polarities.
        drive(1'b0, 1'b1, 1'b0, 24'h0);
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        check("ctl_hs1_vs0", ch0, CTL01);
        check("inv_hs1_vs0", inv_ch0, CTL10);
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        check("ctl_hs0_vs0", ch0, CTL00);
        check("inv_hs0_vs0", inv_ch0, CTL11);

        // Zero data from cnt=0 alternates 0x100 / 0x3FF for nine words.
        for (int i = 0; i < 10; i++) begin
            drive(i < 9, 1'b1, 1'b1, 24'h000000);
            if (i >= 1) begin
                exp_word = ((i - 1) % 2 == 0) ? 10'h100 : 10'h3FF;
                check($sformatf("zero_ch0_%0d", i - 1), ch0, exp_word);
                check($sformatf("zero_ch1_%0d", i - 1), ch1, exp_word);
                check($sformatf("zero_ch2_%0d", i - 1), ch2, exp_word);
            end
        end

        // All ones from cnt=0: 0x200 then 0x0FF.
        drive(1'b1, 1'b1, 1'b1, 24'hFFFFFF);
        drive(1'b1, 1'b1, 1'b1, 24'hFFFFFF);
        check("ones_ch0_0", ch0, 10'h200);
        check("ones_ch2_0", ch2, 10'h200);
        drive(1'b0, 1'b1, 1'b1, 24'h0);
        check("ones_ch0_1", ch0, 10'h0FF);
        check("ones_ch1_1", ch1, 10'h0FF);

        // One-cycle de gap restarts disparity; sync toggles during de=1 are ignored.
        drive(1'b1, 1'b0, 1'b1, 24'h000000);
        drive(1'b0, 1'b1, 1'b1, 24'h000000);
        check("gap_first_ch0", ch0, 10'h100);
        check("gap_first_inv_ch0", inv_ch0, 10'h100);
        drive(1'b1, 1'b1, 1'b0, 24'h000000);
        check("gap_ctl_ch0", ch0, CTL11);
        check("gap_ctl_ch1", ch1, CTL00);
        drive(1'b0, 1'b1, 1'b1, 24'h000000);
        check("gap_second_ch0", ch0, 10'h100);
        check("gap_second_ch1", ch1, 10'h100);
        check("gap_second_ch2", ch2, 10'h100);

        // Mid-line reset clears outputs at once; encoding resumes from cnt=0.
        drive(1'b1, 1'b1, 1'b1, 24'h000000);
        drive(1'b1, 1'b1, 1'b1, 24'h000000);
        check("midrst_pre_ch0", ch0, 10'h100);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ch0", ch0, 10'd0);
        check("midrst_ch1", ch1, 10'd0);
        check("midrst_ch2", ch2, 10'd0);
        step();
        rst_n = 1'b1;
        step();
        check("midrst_rel_ch0", ch0, CTL00);
        step();
        check("midrst_data_ch0", ch0, 10'h100);
        check("midrst_data_ch1", ch1, 10'h100);
        check("midrst_data_ch2", ch2, 10'h100);

        // Short blanked raster with random pixels against the behavioural model.
        drive_model(1'b0, 1'b1, 1'b1, 24'h0);
        for (int line = 0; line < 5; line++) begin
            for (int x = 0; x < 24; x++) begin
                de_s = (line < 4) && (x < 16);
                drive_model(de_s, !(x >= 18 && x < 21), line != 4, 24'($urandom));
            end
        end
        drive_model(1'b0, 1'b1, 1'b1, 24'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
